// File: rtl/kmeans_host_if.sv
// kmeans_host_if: streams one frame (centroids then points) into the k-means core and
// collects the converged centroids as one 64-bit result. Optional macro: KMEANS_TIMEOUT_EN.
module kmeans_host_if #(
  parameter int CLUSTER_SIZE   = 4,
  parameter int DATA_SIZE      = 4096,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [15:0] src_data,
  output logic        km_in_valid,
  output logic [15:0] km_in_data,
  input  logic        km_out_valid,
  input  logic [15:0] km_out_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        err_underrun,
  output logic        err_timeout
);

  localparam logic [12:0] FRAME_LAST = 13'(CLUSTER_SIZE + DATA_SIZE - 1);
  localparam logic [2:0]  CAP_LAST   = 3'(CLUSTER_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN,
    ST_WAIT_RESULT,
    ST_PRESENT,
    ST_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] word_cnt_q, word_cnt_d;
  logic [2:0]  cap_cnt_q, cap_cnt_d;
  logic        km_in_valid_q, km_in_valid_d;
  logic [15:0] km_in_data_q, km_in_data_d;
  logic        res_valid_q, res_valid_d;
  logic [63:0] res_data_q, res_data_d;
  logic        err_underrun_q, err_underrun_d;
  logic        cap_last_s;

`ifdef KMEANS_TIMEOUT_EN
  localparam logic [24:0] TIMEOUT_LAST = 25'(TIMEOUT_CYCLES - 1);
  logic [24:0] wait_cnt_q, wait_cnt_d;
  logic        err_timeout_q, err_timeout_d;
`else
  logic        unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = ^TIMEOUT_CYCLES;
`endif

  // Slot 0 (c0) lands in the most significant halfword.
  function automatic logic [63:0] put_slot(input logic [63:0] cur, input logic [1:0] slot,
                                           input logic [15:0] word);
    logic [63:0] nxt;
    nxt = cur;
    case (slot)
      2'd0:    nxt[63:48] = word;
      2'd1:    nxt[47:32] = word;
      2'd2:    nxt[31:16] = word;
      2'd3:    nxt[15:0]  = word;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  assign cap_last_s = km_out_valid && (cap_cnt_q == CAP_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    cap_cnt_d      = cap_cnt_q;
    km_in_valid_d  = 1'b0;
    km_in_data_d   = 16'h0000;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    err_underrun_d = err_underrun_q;
`ifdef KMEANS_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
    err_timeout_d  = err_timeout_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d        = ST_SEND;
          word_cnt_d     = 13'd0;
          cap_cnt_d      = 3'd0;
          err_underrun_d = 1'b0;
`ifdef KMEANS_TIMEOUT_EN
          err_timeout_d  = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_SEND: begin
        if (src_valid) begin
          km_in_valid_d = 1'b1;
          km_in_data_d  = src_data;
          word_cnt_d    = word_cnt_q + 13'd1;
          if (word_cnt_q == FRAME_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_SEND;
          end
        end else if (word_cnt_q != 13'd0) begin
          // A gap once the burst has begun would corrupt the core's frame.
          err_underrun_d = 1'b1;
          state_d        = ST_ERROR;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DRAIN: begin
        state_d = ST_WAIT_RESULT;
`ifdef KMEANS_TIMEOUT_EN
        wait_cnt_d = 25'd0;
`endif
      end
      ST_WAIT_RESULT: begin
        if (km_out_valid) begin
          res_data_d = put_slot(res_data_q, cap_cnt_q[1:0], km_out_data);
          cap_cnt_d  = cap_cnt_q + 3'd1;
        end else begin
          cap_cnt_d = cap_cnt_q;
        end
        if (cap_last_s) begin
          res_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end else begin
          state_d = ST_WAIT_RESULT;
        end
`ifdef KMEANS_TIMEOUT_EN
        if (cap_last_s) begin
          wait_cnt_d = wait_cnt_q;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 25'd1;
        end
`endif
      end
      ST_PRESENT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      word_cnt_q     <= 13'd0;
      cap_cnt_q      <= 3'd0;
      km_in_valid_q  <= 1'b0;
      km_in_data_q   <= 16'h0000;
      res_valid_q    <= 1'b0;
      res_data_q     <= 64'h0;
      err_underrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      cap_cnt_q      <= cap_cnt_d;
      km_in_valid_q  <= km_in_valid_d;
      km_in_data_q   <= km_in_data_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      err_underrun_q <= err_underrun_d;
    end
  end

`ifdef KMEANS_TIMEOUT_EN
  // Result-wait watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= 25'd0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign busy         = (state_q != ST_IDLE);
  assign src_ready    = (state_q == ST_SEND);
  assign km_in_valid  = km_in_valid_q;
  assign km_in_data   = km_in_data_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_kmeans_host_if.sv
// Directed bench with randomized payloads for kmeans_host_if; expected bursts and results
// come from the word lists the bench itself drives.
module tb_kmeans_host_if;

  localparam int FRAME = 4100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [15:0] src_data = 16'h0000;
  logic        km_in_valid;
  logic [15:0] km_in_data;
  logic        km_out_valid = 1'b0;
  logic [15:0] km_out_data = 16'h0000;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic        err_underrun;
  logic        err_timeout;

  int total = 0;
  int bad = 0;
  int cur_run = 0;
  int ready_bad = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] res_w[4];
  logic [63:0] exp_res = 64'h0;

  kmeans_host_if dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .km_in_valid(km_in_valid), .km_in_data(km_in_data),
    .km_out_valid(km_out_valid), .km_out_data(km_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_underrun(err_underrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (km_in_valid === 1'b1) begin
      rx_q.push_back(km_in_data);
      cur_run++;
    end else begin
      cur_run = 0;
    end
  endtask

  task automatic build_frame(input bit fixed_centroids);
    tx_q.delete();
    if (fixed_centroids) begin
      tx_q.push_back(16'h1010); tx_q.push_back(16'h2020);
      tx_q.push_back(16'h3030); tx_q.push_back(16'h4040);
    end else begin
      for (int i = 0; i < 4; i++) tx_q.push_back(16'($urandom));
    end
    for (int i = 0; i < FRAME - 4; i++) tx_q.push_back(16'($urandom));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive_words(input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_data  = tx_q[i];
      start     = (i == start_at);
      if (src_ready !== 1'b1) ready_bad++;
      step();
    end
    src_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic check_rx(input string tag, input int n);
    int mism;
    mism = 0;
    chk({tag, "_len"}, 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      if (rx_q[i] !== tx_q[i]) mism++;
    end
    chk({tag, "_data"}, 64'(mism), 64'd0);
  endtask

  task automatic full_frame(input string tag, input int start_at);
    int run;
    rx_q.delete();
    ready_bad = 0;
    pulse_start();
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_noburst_yet"}, 64'(km_in_valid), 64'd0);
    drive_words(FRAME, start_at);
    run = cur_run;
    chk({tag, "_ready_low_after"}, 64'(src_ready), 64'd0);
    step();
    chk({tag, "_valid_drop"}, 64'(km_in_valid), 64'd0);
    chk({tag, "_run"}, 64'(run), 64'(FRAME));
    chk({tag, "_ready_during"}, 64'(ready_bad), 64'd0);
    check_rx(tag, FRAME);
  endtask

  task automatic collect_result(input string tag, input bit gaps);
    int early;
    early = 0;
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          km_out_valid = 1'b0;
          km_out_data  = 16'($urandom);
          step();
          if (res_valid !== 1'b0) early++;
        end
      end
      km_out_valid = 1'b1;
      km_out_data  = res_w[k];
      step();
      if (k < 3 && res_valid !== 1'b0) early++;
    end
    km_out_valid = 1'b0;
    exp_res = {res_w[0], res_w[1], res_w[2], res_w[3]};
    chk({tag, "_early"}, 64'(early), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_res_data"}, res_data, exp_res);
    chk({tag, "_busy_present"}, 64'(busy), 64'd1);
  endtask

  task automatic release_result(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_res_valid_clr"}, 64'(res_valid), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cnt;
    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_km_in_valid", 64'(km_in_valid), 64'd0);
    chk("rst_km_in_data", 64'(km_in_data), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_err_underrun", 64'(err_underrun), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Nominal frame and result
    build_frame(1'b1);
    full_frame("nom", -1);
    chk("nom_first_word", 64'(rx_q[0]), 64'h1010);
    res_w[0] = 16'h0A0B; res_w[1] = 16'h1C1D; res_w[2] = 16'h2E2F; res_w[3] = 16'h3031;
    collect_result("nom", 1'b0);
    chk("nom_res_const", res_data, 64'h0A0B1C1D2E2F3031);
    cnt = 0;
    repeat (10) begin
      step();
      if (res_data !== exp_res || res_valid !== 1'b1) cnt++;
    end
    chk("nom_res_stable", 64'(cnt), 64'd0);
    release_result("nom");
    chk("nom_err_timeout", 64'(err_timeout), 64'd0);

    // km_out_valid in idle is ignored
    repeat (3) begin
      km_out_valid = 1'b1;
      km_out_data  = 16'($urandom);
      step();
    end
    km_out_valid = 1'b0;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_res_valid", 64'(res_valid), 64'd0);
    chk("idle_res_hold", res_data, exp_res);

    // Random frame with a stray start mid-burst, result with gaps
    build_frame(1'b0);
    full_frame("rnd", 100);
    for (int k = 0; k < 4; k++) res_w[k] = 16'($urandom);
    collect_result("rnd", 1'b1);
    release_result("rnd");

    // Initial wait then underrun
    build_frame(1'b0);
    rx_q.delete();
    pulse_start();
    cnt = 0;
    repeat (5) begin
      step();
      if (km_in_valid !== 1'b0 || err_underrun !== 1'b0 || busy !== 1'b1) cnt++;
    end
    chk("ur_initial_wait", 64'(cnt), 64'd0);
    drive_words(2000, -1);
    chk("ur_pre_valid", 64'(km_in_valid), 64'd1);
    step();
    chk("ur_valid_low", 64'(km_in_valid), 64'd0);
    chk("ur_data_zero", 64'(km_in_data), 64'd0);
    chk("ur_flag", 64'(err_underrun), 64'd1);
    chk("ur_busy", 64'(busy), 64'd1);
    chk("ur_src_ready", 64'(src_ready), 64'd0);
    check_rx("ur", 2000);
    repeat (3) step();
    chk("ur_sticky", 64'(err_underrun), 64'd1);
    pulse_start();
    chk("ur_clear", 64'(err_underrun), 64'd0);
    chk("ur_restart", 64'(src_ready), 64'd1);

    // Reset mid-burst
    build_frame(1'b0);
    drive_words(1000, -1);
    chk("mid_valid_pre", 64'(km_in_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(km_in_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res_data", res_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Full frame after reset; long wait shows no timeout in this build
    build_frame(1'b0);
    full_frame("post", -1);
    repeat (150) step();
    chk("wait_no_timeout", 64'(err_timeout), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_res_valid", 64'(res_valid), 64'd0);
    for (int k = 0; k < 4; k++) res_w[k] = 16'($urandom);
    collect_result("post", 1'b1);
    release_result("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
